sram_access_arbiter: RTL and testbench

- Shares the single-port external/on-chip audio SRAM between the SPI register path (SPI_TO_SRAM / SRAM_TO_SPI with an auto-incrementing pointer) and the real-time audio-path requester.
- Sits between spi_Interface (sram_control_reg, sram_start_addr_reg, spi_to_sram_reg, sram_to_spi_data) and the SRAM port.
- The audio path normally has priority. A starvation counter bounds how long SPI waits.

---
 rtl/sram_access_arbiter.sv | 127 ++++++++++++
 tb/tb_sram_access_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - shares the single-port audio SRAM between the SPI pointer path and the audio requester
// Audio normally wins; a wait counter lets a starved SPI access through. All SRAM-side outputs are registered.
module sram_access_arbiter #(
  parameter int ADDR_BITS    = 16,
  parameter int DATA_BITS    = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 addr_load,
  input  logic [7:0]           sram_page,
  input  logic [7:0]           sram_start_addr,
  input  logic                 spi_wr_req,
  input  logic [DATA_BITS-1:0] spi_wr_data,
  input  logic                 spi_rd_req,
  output logic [DATA_BITS-1:0] sram_to_spi_data,
  output logic                 spi_rd_done,
  output logic                 spi_overrun,
  output logic [ADDR_BITS-1:0] sram_ptr,
  input  logic                 aud_req,
  input  logic                 aud_we,
  input  logic [ADDR_BITS-1:0] aud_addr,
  input  logic [DATA_BITS-1:0] aud_wdata,
  output logic                 aud_gnt,
  output logic                 aud_rvalid,
  output logic [DATA_BITS-1:0] aud_rdata,
  output logic                 sram_en,
  output logic                 sram_we,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [DATA_BITS-1:0] sram_wdata,
  input  logic [DATA_BITS-1:0] sram_rdata
);

  localparam int CNT_BITS = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {SEL_NONE, SEL_AUD, SEL_WR, SEL_RD} sel_t;

  sel_t                 sel;
  logic                 wr_pend;
  logic                 rd_pend;
  logic [DATA_BITS-1:0] wr_data;
  logic [CNT_BITS-1:0]  wait_cnt;
  logic                 starved;
  logic                 aud_cand;
  logic                 spi_gnt;
  logic [ADDR_BITS-1:0] ptr_eff;
  logic                 spi_rd_issue;
  logic                 rd_cap;

  assign aud_rdata = sram_rdata;

  // A same-cycle addr_load takes effect before any SPI access that issues from it.
  always_comb begin
    ptr_eff  = addr_load ? ADDR_BITS'({sram_page, sram_start_addr}) : sram_ptr;
    starved  = (wait_cnt == CNT_BITS'(STARVE_LIMIT));
    aud_cand = aud_req && !aud_gnt;
    sel      = SEL_NONE;
    if (starved && wr_pend)      sel = SEL_WR;
    else if (starved && rd_pend) sel = SEL_RD;
    else if (aud_cand)           sel = SEL_AUD;
    else if (wr_pend)            sel = SEL_WR;
    else if (rd_pend)            sel = SEL_RD;
    spi_gnt = (sel == SEL_WR) || (sel == SEL_RD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sram_en          <= 1'b0;
      sram_we          <= 1'b0;
      sram_addr        <= '0;
      sram_wdata       <= '0;
      aud_gnt          <= 1'b0;
      aud_rvalid       <= 1'b0;
      spi_rd_issue     <= 1'b0;
      rd_cap           <= 1'b0;
      spi_rd_done      <= 1'b0;
      sram_to_spi_data <= '0;
      sram_ptr         <= '0;
      wr_pend          <= 1'b0;
      rd_pend          <= 1'b0;
      wr_data          <= '0;
      spi_overrun      <= 1'b0;
      wait_cnt         <= '0;
    end else begin
      sram_en      <= (sel != SEL_NONE);
      sram_we      <= ((sel == SEL_AUD) && aud_we) || (sel == SEL_WR);
      aud_gnt      <= (sel == SEL_AUD);
      spi_rd_issue <= (sel == SEL_RD);
      case (sel)
        SEL_AUD: begin
          sram_addr  <= aud_addr;
          sram_wdata <= aud_wdata;
        end
        SEL_WR: begin
          sram_addr  <= ptr_eff;
          sram_wdata <= wr_data;
        end
        SEL_RD:  sram_addr <= ptr_eff;
        default: ;
      endcase

      sram_ptr <= spi_gnt ? ptr_eff + ADDR_BITS'(1) : ptr_eff;

      // Read return: SRAM data is valid the cycle after issue, SPI sees it one cycle later.
      aud_rvalid  <= aud_gnt && !sram_we;
      rd_cap      <= spi_rd_issue;
      spi_rd_done <= rd_cap;
      if (rd_cap) sram_to_spi_data <= sram_rdata;

      if (spi_wr_req && !wr_pend) begin
        wr_pend <= 1'b1;
        wr_data <= spi_wr_data;
      end else if (sel == SEL_WR) begin
        wr_pend <= 1'b0;
      end
      if (spi_rd_req && !rd_pend) rd_pend <= 1'b1;
      else if (sel == SEL_RD)     rd_pend <= 1'b0;

      if (addr_load) spi_overrun <= 1'b0;
      if ((spi_wr_req && wr_pend) || (spi_rd_req && rd_pend)) spi_overrun <= 1'b1;

      if (spi_gnt)                          wait_cnt <= '0;
      else if ((wr_pend || rd_pend) && !starved) wait_cnt <= wait_cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb/tb_sram_access_arbiter.sv - directed bench with transaction scoreboard for sram_access_arbiter
// Expected SRAM accesses are queued at request time; a per-cycle checker matches the port against them.
module tb_sram_access_arbiter;

  localparam int SL = 8;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
    int          tp;
  } acc_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        addr_load = 1'b0;
  logic [7:0]  sram_page = 8'h00;
  logic [7:0]  sram_start_addr = 8'h00;
  logic        spi_wr_req = 1'b0;
  logic [7:0]  spi_wr_data = 8'h00;
  logic        spi_rd_req = 1'b0;
  logic [7:0]  sram_to_spi_data;
  logic        spi_rd_done;
  logic        spi_overrun;
  logic [15:0] sram_ptr;
  logic        aud_req = 1'b0;
  logic        aud_we = 1'b0;
  logic [15:0] aud_addr = 16'h0000;
  logic [7:0]  aud_wdata = 8'h00;
  logic        aud_gnt;
  logic        aud_rvalid;
  logic [7:0]  aud_rdata;
  logic        sram_en;
  logic        sram_we;
  logic [15:0] sram_addr;
  logic [7:0]  sram_wdata;
  logic [7:0]  sram_rdata = 8'h00;

  sram_access_arbiter #(.ADDR_BITS(16), .DATA_BITS(8), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset), .addr_load(addr_load), .sram_page(sram_page),
    .sram_start_addr(sram_start_addr), .spi_wr_req(spi_wr_req), .spi_wr_data(spi_wr_data),
    .spi_rd_req(spi_rd_req), .sram_to_spi_data(sram_to_spi_data), .spi_rd_done(spi_rd_done),
    .spi_overrun(spi_overrun), .sram_ptr(sram_ptr), .aud_req(aud_req), .aud_we(aud_we),
    .aud_addr(aud_addr), .aud_wdata(aud_wdata), .aud_gnt(aud_gnt), .aud_rvalid(aud_rvalid),
    .aud_rdata(aud_rdata), .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cycle_n = 0;
  int aud_grants = 0;
  logic [15:0] model_ptr = 16'h0000;
  logic [7:0]  mem [0:65535];
  logic [7:0]  mdl [0:65535];
  acc_t spi_q[$];
  acc_t exp_aud[$];
  acc_t aud_list[$];

  always @(posedge clk) cycle_n <= cycle_n + 1;

  // SRAM with one-cycle read latency
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= mem[sram_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got an access, expected none", name);
  endtask

  // Audio requester: holds aud_req until granted, then presents the next item.
  acc_t cur;
  initial forever begin
    @(posedge clk); #1;
    if (reset) begin
      aud_req = 1'b0;
      aud_list.delete();
    end else begin
      if (aud_req && aud_gnt) aud_req = 1'b0;
      if (!aud_req && aud_list.size() != 0) begin
        cur = aud_list.pop_front();
        aud_req = 1'b1;
        aud_we = cur.we;
        aud_addr = cur.addr;
        aud_wdata = cur.data;
        exp_aud.push_back(cur);
      end
    end
  end

  // Per-cycle scoreboard
  acc_t ce;
  logic prev_gnt = 1'b0;
  logic rv_exp = 1'b0;
  logic [7:0] rv_data = 8'h00;
  logic rd_p1 = 1'b0, rd_p2 = 1'b0;
  logic [7:0] rd_d1 = 8'h00, rd_d2 = 8'h00;
  initial forever begin
    @(negedge clk);
    if (reset) begin
      spi_q.delete();
      exp_aud.delete();
      prev_gnt = 1'b0;
      rv_exp = 1'b0;
      rd_p1 = 1'b0;
      rd_p2 = 1'b0;
      continue;
    end
    chk("aud_rvalid", aud_rvalid, rv_exp);
    if (rv_exp) chk("aud_rdata", aud_rdata, rv_data);
    rv_exp = 1'b0;
    chk("spi_rd_done", spi_rd_done, rd_p2);
    if (rd_p2) chk("sram_to_spi_data", sram_to_spi_data, rd_d2);
    rd_p2 = rd_p1;
    rd_d2 = rd_d1;
    rd_p1 = 1'b0;
    if (sram_en) begin
      if (aud_gnt) begin
        chk("aud_gnt_gap", prev_gnt, 1'b0);
        if (exp_aud.size() == 0) fail_evt("aud_unexpected");
        else begin
          ce = exp_aud.pop_front();
          aud_grants++;
          chk("aud_access", {sram_we, sram_addr}, {ce.we, ce.addr});
          if (ce.we) begin
            chk("aud_wdata", sram_wdata, ce.data);
            mdl[ce.addr] = ce.data;
          end else begin
            rv_exp = 1'b1;
            rv_data = mdl[ce.addr];
          end
        end
      end else begin
        if (spi_q.size() == 0) fail_evt("spi_unexpected");
        else begin
          ce = spi_q.pop_front();
          chk("spi_access", {sram_we, sram_addr}, {ce.we, ce.addr});
          chk("spi_wait_bound", (cycle_n - ce.tp) <= SL + 2, 1'b1);
          if (ce.we) begin
            chk("spi_wdata", sram_wdata, ce.data);
            mdl[ce.addr] = ce.data;
          end else begin
            rd_p1 = 1'b1;
            rd_d1 = mdl[ce.addr];
          end
        end
      end
    end else begin
      chk("idle_we", sram_we, 1'b0);
      chk("idle_gnt", aud_gnt, 1'b0);
    end
    prev_gnt = aud_gnt;
    if (spi_q.size() == 0 && !addr_load) chk("sram_ptr", sram_ptr, model_ptr);
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic load(input logic [7:0] pg, input logic [7:0] off);
    addr_load = 1'b1;
    sram_page = pg;
    sram_start_addr = off;
    model_ptr = {pg, off};
    cyc();
    addr_load = 1'b0;
  endtask

  task automatic spi_wr(input logic [7:0] d, input bit drop = 1'b0);
    spi_wr_req = 1'b1;
    spi_wr_data = d;
    if (!drop) begin
      spi_q.push_back('{1'b1, model_ptr, d, cycle_n});
      model_ptr = model_ptr + 16'h1;
    end
    cyc();
    spi_wr_req = 1'b0;
  endtask

  task automatic wr_check(input logic [7:0] d, input logic [15:0] a);
    spi_wr(d);
    cyc();
    @(negedge clk);
    chk("wr_issue", {sram_en, sram_we, sram_addr, sram_wdata}, {1'b1, 1'b1, a, d});
    cyc();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((aud_req || aud_list.size() != 0 || spi_q.size() != 0) && n < 300) begin
      cyc();
      n++;
    end
    chk(name, n < 300, 1'b1);
    cyc(3);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int quiet;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'(i) ^ 8'(i >> 8);
      mdl[i] = 8'(i) ^ 8'(i >> 8);
    end
    mem[16'h2000] = 8'h5A;
    mdl[16'h2000] = 8'h5A;

    cyc(3);
    @(negedge clk);
    chk("reset_outputs", {sram_en, sram_we, sram_addr, sram_wdata, aud_gnt, aud_rvalid, spi_rd_done, spi_overrun, sram_ptr, sram_to_spi_data}, 64'h0);
    cyc();
    reset = 1'b0;
    cyc();

    load(8'h12, 8'h34);
    spi_wr(8'hA5);
    @(negedge clk);
    chk("wr_not_early", sram_en, 1'b0);
    cyc();
    @(negedge clk);
    chk("wr_first", {sram_en, sram_we, sram_addr, sram_wdata}, {1'b1, 1'b1, 16'h1234, 8'hA5});
    chk("ptr_after_wr", sram_ptr, 16'h1235);
    cyc(2);

    load(8'h03, 8'hFF);
    wr_check(8'h11, 16'h03FF);
    wr_check(8'h22, 16'h0400);
    @(negedge clk);
    chk("ptr_page_carry", sram_ptr, 16'h0401);
    cyc();
    load(8'hFF, 8'hFF);
    wr_check(8'h33, 16'hFFFF);
    @(negedge clk);
    chk("ptr_wrap", sram_ptr, 16'h0000);
    cyc();

    load(8'h20, 8'h00);
    spi_rd_req = 1'b1;
    spi_q.push_back('{1'b0, model_ptr, 8'h00, cycle_n});
    model_ptr = model_ptr + 16'h1;
    cyc();
    spi_rd_req = 1'b0;
    cyc();
    @(negedge clk);
    chk("rd_issue", {sram_en, sram_we, sram_addr}, {1'b1, 1'b0, 16'h2000});
    cyc();
    @(negedge clk);
    chk("rd_done_not_early", spi_rd_done, 1'b0);
    cyc();
    @(negedge clk);
    chk("rd_done_data", {spi_rd_done, sram_to_spi_data}, {1'b1, 8'h5A});
    cyc(2);

    load(8'h40, 8'h00);
    aud_grants = 0;
    for (int k = 0; k < 8; k++) aud_list.push_back('{k[0], 16'h8000 + 16'(k * 3), 8'hC0 + 8'(k), 0});
    cyc(3);
    spi_wr(8'h77);
    drain("aud_spi_drain");
    chk("aud_grant_count", aud_grants, 8);

    chk("overrun_clear_before", spi_overrun, 1'b0);
    load(8'h41, 8'h00);
    for (int k = 0; k < 10; k++) aud_list.push_back('{~k[0], 16'h9000 + 16'(k), 8'h30 + 8'(k), 0});
    cyc(2);
    spi_wr(8'h99);
    spi_wr(8'h66, 1'b1);
    drain("overrun_drain");
    chk("overrun_set", spi_overrun, 1'b1);
    chk("overrun_one_write", mem[16'h4100], 8'h99);
    load(8'h42, 8'h00);
    @(negedge clk);
    chk("overrun_cleared", spi_overrun, 1'b0);
    cyc();

    for (int k = 0; k < 6; k++) aud_list.push_back('{1'b0, 16'hA000 + 16'(k), 8'h00, 0});
    cyc(3);
    spi_wr_req = 1'b1;
    spi_rd_req = 1'b1;
    spi_wr_data = 8'hEE;
    spi_q.push_back('{1'b1, model_ptr, 8'hEE, cycle_n});
    spi_q.push_back('{1'b0, model_ptr + 16'h1, 8'h00, cycle_n});
    cyc();
    spi_wr_req = 1'b0;
    spi_rd_req = 1'b0;
    reset = 1'b1;
    model_ptr = 16'h0000;
    cyc();
    @(negedge clk);
    chk("midop_reset_outputs", {sram_en, sram_we, sram_addr, sram_wdata, aud_gnt, aud_rvalid, spi_rd_done, spi_overrun, sram_ptr, sram_to_spi_data}, 64'h0);
    cyc();
    reset = 1'b0;
    quiet = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (sram_en || spi_rd_done || aud_rvalid) quiet++;
      cyc();
    end
    chk("post_reset_quiet", quiet, 0);
    chk("no_write_after_reset", mem[16'h4200], 8'h42);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
